// File: rtl/float_act_pkg.sv
// Purpose : shared types and fp32 constants for the vector activation block.
// Latency : n/a (package only).
// Backpressure: n/a.
// Contents: act_mode_t (SIGMOID/RELU/PASS/reserved), FP_ZERO/FP_HALF/FP_ONE/FP_QNAN.
package float_act_pkg;

  typedef enum logic [1:0] {
    ACT_SIGMOID = 2'd0,
    ACT_RELU    = 2'd1,
    ACT_PASS    = 2'd2,
    ACT_RSVD    = 2'd3   // behaves as PASS
  } act_mode_t;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_HALF = 32'h3F00_0000;
  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

endpackage

// File: rtl/float_sigmoid_lane.sv
// Purpose : one fp32 lane: sigmoid(x) = 1/(1+exp(-x)), plus the untouched operand delayed alongside.
// Latency : exactly LATENCY register stages from i_x to o_x/o_sig.
// Backpressure: none; the lane never stalls, a new operand may enter every cycle.
// Ports   : clk; i_x fp32 operand; o_x delayed operand; o_sig sigmoid result.
// The exp/add-one/reciprocal chain is realised here by a portable piecewise-linear
// evaluation (|err| < ~0.02); a vendor fp core can be swapped in behind this boundary
// as long as the total delay stays LATENCY.
module float_sigmoid_lane
  import float_act_pkg::*;
#(
  parameter int LATENCY = 27
) (
  input  logic        clk,
  input  logic [31:0] i_x,
  output logic [31:0] o_x,
  output logic [31:0] o_sig
);

  logic [7:0]  w_e;
  logic [23:0] w_m;
  logic [19:0] w_fix;   // |x| in unsigned Q4.16, clamped
  logic [16:0] w_y;     // sigmoid(|x|) in Q1.16, range [0.5, 1.0]
  logic [16:0] w_r;     // sigmoid(x) after sign fold
  logic [4:0]  w_p;     // leading-one position of w_r
  logic [22:0] w_man;
  logic [31:0] w_sig;

  always_comb begin
    w_e   = i_x[30:23];
    w_m   = {1'b1, i_x[22:0]};
    w_fix = '0;
    // |x| >= 16 (including inf/NaN) lands in the flat region anyway;
    // below 2^-16 the fixed-point value rounds to zero.
    if (w_e >= 8'h83) begin
      w_fix = 20'hF_FFFF;
    end else if (w_e >= 8'd111) begin
      w_fix = 20'(w_m >> (8'd134 - w_e));
    end

    if (w_fix < 20'd65536) begin
      w_y = 17'(w_fix >> 2) + 17'd32768;      // 0.25|x|    + 0.5
    end else if (w_fix < 20'd155648) begin
      w_y = 17'(w_fix >> 3) + 17'd40960;      // 0.125|x|   + 0.625
    end else if (w_fix < 20'd327680) begin
      w_y = 17'(w_fix >> 5) + 17'd55296;      // 0.03125|x| + 0.84375
    end else begin
      w_y = 17'd65536;
    end

    // sigmoid(-x) = 1 - sigmoid(x)
    w_r = i_x[31] ? (17'd65536 - w_y) : w_y;

    w_p = '0;
    for (int i = 0; i < 17; i++) begin
      if (w_r[i]) w_p = 5'(i);
    end
    // Cast drops the hidden leading one.
    w_man = 23'({7'd0, w_r} << (5'd23 - w_p));
    w_sig = (w_r == '0) ? FP_ZERO : {1'b0, 8'd111 + {3'd0, w_p}, w_man};
  end

  logic [31:0] r_x [LATENCY];
  logic [31:0] r_s [LATENCY];

  // Pure datapath: validity travels in the caller's tag pipe, so no reset here.
  always_ff @(posedge clk) begin
    r_x[0] <= i_x;
    r_s[0] <= w_sig;
    for (int i = 1; i < LATENCY; i++) begin
      r_x[i] <= r_x[i-1];
      r_s[i] <= r_s[i-1];
    end
  end

  assign o_x   = r_x[LATENCY-1];
  assign o_sig = r_s[LATENCY-1];

endmodule

// File: rtl/float_activation_vec.sv
// Purpose : LANES-wide fp32 activation (SIGMOID / RELU / PASS) with an output buffer.
// Latency : result enters the buffer LATENCY cycles after acceptance; out_valid one cycle later.
// Backpressure: in_ready drops when in-flight + buffered beats reach FIFO_DEPTH; pipe never stalls.
// Ports   : clk, reset (async, active-low); in_data/in_mode/in_valid/in_ready input beat;
//           out_data/out_valid/out_ready output beat; occupancy = in-flight + buffered.
// Option  : FLOAT_ACT_SATURATE_EN forces SIGMOID results for |x|>=16 and NaN.
module float_activation_vec
  import float_act_pkg::*;
#(
  parameter int LANES      = 4,
  parameter int LATENCY    = 27,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [LANES*32-1:0]               in_data,
  input  logic [1:0]                        in_mode,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [LANES*32-1:0]               out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   occupancy
);

  localparam int OW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [OW-1:0] DEPTH_C  = OW'(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);

  // The buffer must absorb everything in flight when the consumer stops.
  if (FIFO_DEPTH < LATENCY + 2) begin : g_depth_chk
    $error("float_activation_vec: FIFO_DEPTH must be >= LATENCY+2");
  end

  logic [OW-1:0] r_occ;
  logic [OW-1:0] r_cnt;
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic          w_acc;
  logic          w_pop;
  logic          w_push;

  // Counting in-flight beats guarantees a buffer slot for every accepted beat.
  assign in_ready  = reset && (r_occ < DEPTH_C);
  assign w_acc     = in_valid && in_ready;
  assign out_valid = (r_cnt != '0);
  assign w_pop     = out_valid && out_ready;
  assign occupancy = r_occ;

  // Tag pipe: beat valid + mode, aligned with the lane datapath.
  logic      r_tag_vld  [LATENCY];
  act_mode_t r_tag_mode [LATENCY];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_tag_vld[i]  <= 1'b0;
        r_tag_mode[i] <= ACT_PASS;
      end
    end else begin
      r_tag_vld[0]  <= w_acc;
      r_tag_mode[0] <= act_mode_t'(in_mode);
      for (int i = 1; i < LATENCY; i++) begin
        r_tag_vld[i]  <= r_tag_vld[i-1];
        r_tag_mode[i] <= r_tag_mode[i-1];
      end
    end
  end

  act_mode_t           w_mode_out;
  logic [LANES*32-1:0] w_res_vec;

  assign w_mode_out = r_tag_mode[LATENCY-1];
  assign w_push     = r_tag_vld[LATENCY-1];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [31:0] w_x;
    logic [31:0] w_sig;
    logic [31:0] w_res;

    float_sigmoid_lane #(.LATENCY(LATENCY)) u_lane (
      .clk   (clk),
      .i_x   (in_data[32*g +: 32]),
      .o_x   (w_x),
      .o_sig (w_sig)
    );

    always_comb begin
      w_res = w_x;
      case (w_mode_out)
        ACT_SIGMOID: begin
`ifdef FLOAT_ACT_SATURATE_EN
          if ((w_x[30:23] == 8'hFF) && (w_x[22:0] != '0)) begin
            w_res = FP_QNAN;
          end else if (w_x[30:23] >= 8'h83) begin
            w_res = w_x[31] ? FP_ZERO : FP_ONE;
          end else begin
            w_res = w_sig;
          end
`else
          w_res = w_sig;
`endif
        end
        ACT_RELU: w_res = w_x[31] ? FP_ZERO : w_x;  // -0.0 also maps to +0
        default:  w_res = w_x;
      endcase
    end

    assign w_res_vec[32*g +: 32] = w_res;
  end

  // Output buffer storage: no reset needed, emptiness lives in r_cnt.
  logic [LANES*32-1:0] r_mem [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_res_vec;
  end

  assign out_data = r_mem[r_rptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_occ  <= '0;
      r_cnt  <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      assert (!(w_push && (r_cnt == DEPTH_C)));

      if (w_acc && !w_pop)      r_occ <= r_occ + OW'(1);
      else if (!w_acc && w_pop) r_occ <= r_occ - OW'(1);

      if (w_push && !w_pop)      r_cnt <= r_cnt + OW'(1);
      else if (!w_push && w_pop) r_cnt <= r_cnt - OW'(1);

      if (w_push) r_wptr <= (r_wptr == PTR_LAST) ? '0 : r_wptr + PW'(1);
      if (w_pop)  r_rptr <= (r_rptr == PTR_LAST) ? '0 : r_rptr + PW'(1);
    end
  end

endmodule

// File: doc/float_activation_vec.md
FLOAT_ACTIVATION_VEC -- requirements
Module: float_activation_vec

Interface
REQ-001 SHALL have parameter LANES, default 4, number of parallel fp32 lanes per beat.
REQ-002 SHALL have parameter LATENCY, default 27, fixed cycle latency of the lane arithmetic.
REQ-003 SHALL have parameter FIFO_DEPTH, default 32, output buffer entries; elaboration SHALL fail if FIFO_DEPTH < LATENCY+2.
REQ-004 SHALL have port: clk  input  1  single clock, all logic rising-edge.
REQ-005 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port: in_data  input  LANES*32  fp32 operands, lane i at bits [32i+31:32i].
REQ-007 SHALL have port: in_mode  input  2  act_mode_t: 0 SIGMOID, 1 RELU, 2 PASS, 3 reserved (treated as PASS).
REQ-008 SHALL have port: in_valid  input  1  beat offered.
REQ-009 SHALL have port: in_ready  output  1  beat can be accepted.
REQ-010 SHALL have port: out_data  output  LANES*32  results, same lane packing.
REQ-011 SHALL have port: out_valid  output  1  head of output buffer valid.
REQ-012 SHALL have port: out_ready  input  1  consumer takes head.
REQ-013 SHALL have port: occupancy  output  $clog2(FIFO_DEPTH+1)  in-flight beats plus buffered beats.

Function
REQ-014 Beat SHALL be accepted exactly when in_valid && in_ready at a rising edge.
REQ-015 in_ready SHALL equal (occupancy < FIFO_DEPTH), combinational from registered counters; lane pipeline never stalls.
REQ-016 SIGMOID lane result SHALL be 1/(1+exp(-x)) as computed by the lane core.
REQ-017 RELU lane result SHALL be 0x00000000 when sign bit set (incl. -0.0), else x unchanged.
REQ-018 PASS lane result SHALL be x unchanged.
REQ-019 All modes SHALL have identical latency: result written into the buffer exactly LATENCY cycles after acceptance; beat order preserved.
REQ-020 Per-beat valid and mode tags SHALL travel in a LATENCY-deep shift register alongside the data.
REQ-021 out_valid SHALL be 1 iff buffer non-empty; out_data SHALL show head entry; pop on out_valid && out_ready.
REQ-022 Simultaneous push and pop SHALL leave buffer count unchanged; push into full buffer is impossible by REQ-015 and SHALL be asserted against in simulation.
REQ-023 occupancy SHALL increment on accept, decrement on pop, unchanged when both occur in one cycle.
REQ-024 Buffer pointers SHALL wrap modulo FIFO_DEPTH; non-power-of-two depths SHALL work.
REQ-025 With out_ready held 1 and in_valid held 1, throughput SHALL be one beat per cycle indefinitely.

Reset
REQ-026 While reset low: in_ready=0, out_valid=0, occupancy=0, all tag valid bits 0, buffer empty.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight and buffered beats; no stale beat SHALL appear after release.
REQ-028 in_ready SHALL rise in the first cycle after reset deasserts; out_data value under out_valid=0 is don't-care.

Configuration
REQ-029 Macro FLOAT_ACT_SATURATE_EN, when defined, SHALL force SIGMOID results: |x|>=16.0 (biased exponent >= 0x83) gives 0x3F800000 if positive, 0x00000000 if negative; NaN input gives 0x7FC00000; override applied at lane output, latency unchanged.
REQ-030 Without FLOAT_ACT_SATURATE_EN, SIGMOID results SHALL be the raw lane-core output for all inputs and no override logic SHALL exist.

Structure
REQ-031 Package float_act_pkg SHALL hold act_mode_t and constants FP_ZERO, FP_HALF (0x3F000000), FP_ONE (0x3F800000), FP_QNAN (0x7FC00000).
REQ-032 Sub-module float_sigmoid_lane SHALL implement one lane's exp, add-one, reciprocal chain with fixed LATENCY and no stall input; vendor core selection stays inside it.
REQ-033 Top SHALL instantiate LANES copies of float_sigmoid_lane plus tag shift register, output buffer and counters.

Verification
REQ-034 Single SIGMOID beat x=0.0 all lanes -> out_valid rises LATENCY+1 cycles after accept, out_data lanes = 0x3F000000.
REQ-035 RELU beat lanes {0xC0000000, 0x80000000, 0x40400000, 0x3F800000} -> {0x00000000, 0x00000000, 0x40400000, 0x3F800000}.
REQ-036 out_ready=0, in_valid=1 continuously -> exactly FIFO_DEPTH beats accepted, in_ready falls, occupancy=FIFO_DEPTH; release out_ready -> all beats drain in order, no loss.
REQ-037 Alternating modes, random out_ready at 50% -> output stream matches reference model order and values.
REQ-038 Reset pulsed with 10 beats in flight -> after release occupancy=0, out_valid never rises until new input, in_ready=1.
REQ-039 FLOAT_ACT_SATURATE_EN defined, SIGMOID x=20.0 (0x41A00000), x=-20.0, x=NaN -> 0x3F800000, 0x00000000, 0x7FC00000.
